// File: rtl/da_rom_seq_if.sv
// Bus bundle for the DA ROM sequencer: sample handshake, ROM port and result handshake.
// The sequencer takes the slave view; the sample source, ROM and result sink take the master view.
interface da_rom_seq_if #(
   parameter int DW    = 8,
   parameter int ROM_W = 16,
   parameter int ACC_W = ROM_W + DW
);
   logic             in_valid;
   logic             in_ready;
   logic [DW-1:0]    x0;
   logic [DW-1:0]    x1;
   logic [DW-1:0]    x2;
   logic             rom_cs;
   logic [2:0]       rom_addr;
   logic [ROM_W-1:0] rom_data;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] result;

   modport master (
      output in_valid, x0, x1, x2, rom_data, out_ready,
      input  in_ready, rom_cs, rom_addr, out_valid, result
   );

   modport slave (
      input  in_valid, x0, x1, x2, rom_data, out_ready,
      output in_ready, rom_cs, rom_addr, out_valid, result
   );
endinterface

// File: rtl/da_rom_seq.sv
// Bit-serial distributed-arithmetic sequencer: walks the bit-planes of a sample triple LSB first
// through a 3-input coefficient ROM and shift-accumulates the partial sums into one DCT term.
//
// state  | meaning
// IDLE   | waiting for a sample triple, in_ready high once reset release has synchronised
// RUN    | DW cycles, one bit-plane per cycle, ROM selected, accumulator updating
// DONE   | result presented with out_valid until out_ready is sampled high
module da_rom_seq #(
   parameter int DW    = 8,
   parameter int ROM_W = 16,
   parameter int ACC_W = ROM_W + DW
) (
   input logic        clk,
   input logic        rst_n,
   da_rom_seq_if.slave bus
);

   localparam int KW = (DW > 1) ? $clog2(DW) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic             r_rst_meta;
   logic             r_rst_sync;
   logic [1:0]       r_state;
   logic [DW-1:0]    r_sh0;
   logic [DW-1:0]    r_sh1;
   logic [DW-1:0]    r_sh2;
   logic [KW-1:0]    r_k;
   logic [ACC_W-1:0] r_acc;
   logic [ACC_W-1:0] r_result;
   logic             r_out_valid;
   logic             r_rom_cs;
   logic [2:0]       r_rom_addr;

   logic             w_in_ready;
   logic             w_accept;
   logic             w_last;
   logic [ACC_W-1:0] w_rom_sext;
   logic [ACC_W-1:0] w_term;
   logic [ACC_W-1:0] w_acc_next;

   // Two-stage release so in_ready lines up with the ROM's own reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rst_meta <= 1'b0;
         r_rst_sync <= 1'b0;
      end else begin
         r_rst_meta <= 1'b1;
         r_rst_sync <= r_rst_meta;
      end
   end

   assign w_in_ready = (r_state == S_IDLE) && r_rst_sync;
   assign w_accept   = bus.in_valid && w_in_ready;
   assign w_last     = (r_k == KW'(DW - 1));

   assign w_rom_sext = {{(ACC_W - ROM_W){bus.rom_data[ROM_W-1]}}, bus.rom_data};
   assign w_term     = w_rom_sext << r_k;
   // The MSB plane carries negative weight in two's complement.
   assign w_acc_next = w_last ? (r_acc - w_term) : (r_acc + w_term);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_sh0       <= '0;
         r_sh1       <= '0;
         r_sh2       <= '0;
         r_k         <= '0;
         r_acc       <= '0;
         r_result    <= '0;
         r_out_valid <= 1'b0;
         r_rom_cs    <= 1'b0;
         r_rom_addr  <= 3'b000;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_sh0      <= bus.x0;
                  r_sh1      <= bus.x1;
                  r_sh2      <= bus.x2;
                  r_acc      <= '0;
                  r_k        <= '0;
                  r_rom_cs   <= 1'b1;
                  r_rom_addr <= {bus.x0[0], bus.x1[0], bus.x2[0]};
                  r_state    <= S_RUN;
               end
            end
            S_RUN: begin
               r_sh0      <= r_sh0 >> 1;
               r_sh1      <= r_sh1 >> 1;
               r_sh2      <= r_sh2 >> 1;
               r_acc      <= w_acc_next;
               r_k        <= r_k + KW'(1);
               // Address is registered one plane ahead so the ROM sees a glitch-free bus.
               r_rom_addr <= {r_sh0[1], r_sh1[1], r_sh2[1]};
               if (w_last) begin
                  r_k         <= '0;
                  r_result    <= w_acc_next;
                  r_out_valid <= 1'b1;
                  r_rom_cs    <= 1'b0;
                  r_rom_addr  <= 3'b000;
                  r_state     <= S_DONE;
               end
            end
            S_DONE: begin
               if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_out_valid <= 1'b0;
               r_rom_cs    <= 1'b0;
               r_rom_addr  <= 3'b000;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.rom_cs    = r_rom_cs;
   assign bus.rom_addr  = r_rom_addr;
   assign bus.out_valid = r_out_valid;
   assign bus.result    = r_result;

endmodule

// File: tb/tb_da_rom_seq.sv
// Directed bench for da_rom_seq: a transaction-level DA model checked every cycle,
// plus hand-computed result literals for the test-plan cases.
module tb_da_rom_seq;

   localparam int DW    = 8;
   localparam int ROM_W = 16;
   localparam int ACC_W = 24;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   int n_checks = 0;
   int n_errors = 0;

   logic signed [ROM_W-1:0] rom [0:7];
   initial begin
      rom[0] = 16'sh0000; rom[1] = 16'shE782; rom[2] = 16'sh3B21; rom[3] = 16'sh22A3;
      rom[4] = 16'shC4DF; rom[5] = 16'shAC61; rom[6] = 16'sh0000; rom[7] = 16'shE782;
   end

   da_rom_seq_if #(.DW(DW), .ROM_W(ROM_W), .ACC_W(ACC_W)) bus ();

   da_rom_seq #(.DW(DW), .ROM_W(ROM_W), .ACC_W(ACC_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   assign bus.rom_data = bus.rom_cs ? rom[bus.rom_addr] : '0;

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // DA sum straight from the definition: sum over planes of ROM[bits]*2^k, MSB plane negated.
   function automatic logic [ACC_W-1:0] da_model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                                 input logic [DW-1:0] c);
      longint s;
      longint v;
      logic [2:0] idx;
      s = 0;
      for (int k = 0; k < DW; k++) begin
         idx = {a[k], b[k], c[k]};
         v   = rom[idx];
         if (k == DW - 1) s = s - v * (longint'(1) << k);
         else             s = s + v * (longint'(1) << k);
      end
      return s[ACC_W-1:0];
   endfunction

   // Transaction model: phase 0 idle, 1..DW one plane each, DW+1 result held.
   int               m_sync   = 0;
   int               m_phase  = 0;
   logic [DW-1:0]    m_x0     = '0;
   logic [DW-1:0]    m_x1     = '0;
   logic [DW-1:0]    m_x2     = '0;
   logic [ACC_W-1:0] m_result = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_sync   = 0;
         m_phase  = 0;
         m_result = '0;
      end else begin
         if (m_phase == 0) begin
            if (m_sync >= 2 && bus.in_valid) begin
               m_x0    = bus.x0;
               m_x1    = bus.x1;
               m_x2    = bus.x2;
               m_phase = 1;
            end
         end else if (m_phase <= DW) begin
            m_phase = m_phase + 1;
            if (m_phase == DW + 1) m_result = da_model(m_x0, m_x1, m_x2);
         end else if (bus.out_ready) begin
            m_phase = 0;
         end
         if (m_sync < 2) m_sync = m_sync + 1;
      end
   end

   always @(negedge clk) begin
      logic       e_ready;
      logic       e_cs;
      logic [2:0] e_addr;
      logic       e_valid;
      int         k;
      e_ready = (m_phase == 0) && (m_sync >= 2);
      e_cs    = (m_phase >= 1) && (m_phase <= DW);
      e_valid = (m_phase == DW + 1);
      e_addr  = 3'b000;
      if (e_cs) begin
         k      = m_phase - 1;
         e_addr = {m_x0[k], m_x1[k], m_x2[k]};
      end
      chk("in_ready",  32'(bus.in_ready),  32'(e_ready));
      chk("rom_cs",    32'(bus.rom_cs),    32'(e_cs));
      chk("rom_addr",  32'(bus.rom_addr),  32'(e_addr));
      chk("out_valid", 32'(bus.out_valid), 32'(e_valid));
      chk("result",    32'(bus.result),    32'(m_result));
   end

   // hold > 0: keep out_ready low that many cycles in DONE while offering the triple (0,1,0).
   task automatic run_triple(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] c,
                             input logic [ACC_W-1:0] lit, input bit use_lit, input int hold);
      int n;
      @(posedge clk); #1;
      bus.x0 = a; bus.x1 = b; bus.x2 = c;
      bus.in_valid = 1'b1;
      n = 0;
      while (!bus.in_ready && n < 30) begin
         @(posedge clk); #1;
         n++;
      end
      if (!bus.in_ready) chk("accept_timeout", 32'(bus.in_ready), 32'd1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.x0 = DW'($urandom); bus.x1 = DW'($urandom); bus.x2 = DW'($urandom);
      n = 1;
      while (!bus.out_valid && n < 30) begin
         @(posedge clk); #1;
         n++;
      end
      chk("latency_edges", 32'(n), 32'(DW + 1));
      if (use_lit) begin
         chk("result_lit", 32'(bus.result), 32'(lit));
         chk("model_lit",  32'(da_model(a, b, c)), 32'(lit));
      end
      if (hold > 0) begin
         bus.x0 = 8'h00; bus.x1 = 8'h01; bus.x2 = 8'h00;
         bus.in_valid = 1'b1;
         for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid",  32'(bus.out_valid), 32'd1);
            chk("hold_ready",  32'(bus.in_ready),  32'd0);
            if (use_lit) chk("hold_result", 32'(bus.result), 32'(lit));
         end
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
   endtask

   initial begin
      int n;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.x0 = '0; bus.x1 = '0; bus.x2 = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_ready_edge1", 32'(bus.in_ready), 32'd0);
      chk("rst_cs",          32'(bus.rom_cs),   32'd0);
      chk("rst_result",      32'(bus.result),   32'h000000);
      @(posedge clk); #1;
      chk("rst_ready_edge2", 32'(bus.in_ready), 32'd1);

      run_triple(8'h00, 8'h01, 8'h00, 24'h003B21, 1'b1, 0);
      run_triple(8'h00, 8'h00, 8'h01, 24'hFFE782, 1'b1, 0);
      run_triple(8'h00, 8'h00, 8'hFF, 24'h00187E, 1'b1, 0);
      run_triple(8'h01, 8'h00, 8'h01, 24'hFFAC61, 1'b1, 0);
      run_triple(8'h02, 8'h00, 8'h00, 24'hFF89BE, 1'b1, 0);
      run_triple(8'h7F, 8'h80, 8'h55, 24'h0, 1'b0, 0);
      run_triple(8'hA5, 8'h3C, 8'hFF, 24'h0, 1'b0, 0);
      run_triple(8'h80, 8'h80, 8'h80, 24'h0, 1'b0, 0);

      // Backpressure: the held triple is taken on the first edge back in IDLE.
      run_triple(8'h00, 8'h00, 8'hFF, 24'h00187E, 1'b1, 5);
      chk("bp_idle_ready", 32'(bus.in_ready), 32'd1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      chk("bp_accepted_cs", 32'(bus.rom_cs), 32'd1);
      n = 1;
      while (!bus.out_valid && n < 30) begin
         @(posedge clk); #1;
         n++;
      end
      chk("bp_latency", 32'(n), 32'(DW + 1));
      chk("bp_result",  32'(bus.result), 32'h003B21);
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;

      // Abort at k=4 of RUN.
      @(posedge clk); #1;
      bus.x0 = 8'hFF; bus.x1 = 8'h5A; bus.x2 = 8'h33;
      bus.in_valid = 1'b1;
      n = 0;
      while (!bus.in_ready && n < 30) begin
         @(posedge clk); #1;
         n++;
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      chk("abort_cs_before", 32'(bus.rom_cs), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_cs",     32'(bus.rom_cs),    32'd0);
      chk("abort_valid",  32'(bus.out_valid), 32'd0);
      chk("abort_result", 32'(bus.result),    32'h000000);
      chk("abort_ready",  32'(bus.in_ready),  32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      run_triple(8'h01, 8'h00, 8'h01, 24'hFFAC61, 1'b1, 0);
      run_triple(8'h02, 8'h00, 8'h00, 24'hFF89BE, 1'b1, 0);

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

endmodule
